// File: rtl/mmio_console.sv
// CPU data-port bridge: RAM pass-through plus a three-word console window
// (DATA/STATUS/SENT) that feeds a byte TX FIFO drained over valid/ready.
module mmio_console #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] CONSOLE_BASE = 16'hFFF0,
    parameter int                FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_write_enable,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   sent_q, sent_d;

    logic hit_data, hit_status, hit_sent, console_hit;
    logic full, empty, push, pop, refuse;
    logic [7:0]  cnt8;
    logic [31:0] status_word;

    always_comb begin
        hit_data    = cpu_address == CONSOLE_BASE;
        hit_status  = cpu_address == CONSOLE_BASE + ADDR_W'(4);
        hit_sent    = cpu_address == CONSOLE_BASE + ADDR_W'(8);
        console_hit = hit_data | hit_status | hit_sent;

        full   = count_q == CW'(FIFO_DEPTH);
        empty  = count_q == '0;
        // Full is judged before any same-cycle pop: no pass-through into a full FIFO.
        push   = cpu_write_enable & hit_data & ~full & reset;
        refuse = cpu_write_enable & hit_data & full & reset;
        pop    = ~empty & tx_ready;

        cnt8        = 8'(count_q);
        status_word = {16'b0, cnt8, 6'b0, overflow_q, full};
    end

    assign ram_address      = cpu_address;
    assign ram_wdata        = cpu_wdata;
    assign ram_write_enable = cpu_write_enable & ~console_hit;
    assign cpu_stall        = refuse;
    assign tx_valid         = ~empty;
    assign tx_data          = mem_q[rd_ptr_q];

    always_comb begin
        cpu_rdata = ram_rdata;
        if (hit_data)   cpu_rdata = 32'b0;
        if (hit_status) cpu_rdata = status_word;
        if (hit_sent)   cpu_rdata = sent_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sent_d     = sent_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            sent_d   = sent_q + 32'd1;
        end
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (refuse)
            overflow_d = 1'b1;
        else if (cpu_write_enable && hit_status && cpu_wdata[1])
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sent_q     <= 32'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sent_q     <= sent_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define content.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cpu_wdata[7:0];
    end
endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: queue-based console model, bench-side RAM, directed
// scenarios plus a randomized mixed-traffic run.
module tb_mmio_console;
    localparam int          AW   = 16;
    localparam int          D    = 8;
    localparam logic [15:0] BASE = 16'hFFF0;
    localparam logic [15:0] STA  = 16'hFFF4;
    localparam logic [15:0] SNT  = 16'hFFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_address = '0;
    logic        cpu_write_enable = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [15:0] ram_address;
    logic        ram_write_enable;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int pass = 0;
    int total = 0;

    logic [7:0]  mq [$];
    logic [31:0] msent = 0;
    logic        movf = 1'b0;
    logic [31:0] ram_mem [256];

    mmio_console #(.ADDR_W(AW), .CONSOLE_BASE(BASE), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(rst_n),
        .cpu_address(cpu_address), .cpu_write_enable(cpu_write_enable),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (ram_write_enable) ram_mem[ram_address[9:2]] <= ram_wdata;
    assign ram_rdata = ram_mem[ram_address[9:2]];

    function automatic logic [31:0] mstatus();
        logic [7:0] c;
        c = 8'(mq.size());
        return {16'b0, c, 6'b0, movf, (mq.size() == D)};
    endfunction

    function automatic logic mstall();
        return cpu_write_enable && cpu_address == BASE && mq.size() == D && rst_n;
    endfunction

    task automatic drv(input logic we, input logic [15:0] a, input logic [31:0] wd, input logic rdy);
        cpu_write_enable = we; cpu_address = a; cpu_wdata = wd; tx_ready = rdy;
    endtask

    // Advance one clock edge and apply the console rules to the model.
    task automatic tick();
        logic full, pop;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete(); msent = 0; movf = 1'b0;
        end else begin
            full = mq.size() == D;
            pop  = mq.size() != 0 && tx_ready;
            if (pop) begin void'(mq.pop_front()); msent = msent + 1; end
            if (cpu_write_enable && cpu_address == BASE) begin
                if (full) movf = 1'b1;
                else mq.push_back(cpu_wdata[7:0]);
            end else if (cpu_write_enable && cpu_address == STA && cpu_wdata[1]) movf = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        drv(1, BASE, 32'h55, 1); #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", tx_valid); else pass++;
        total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", cpu_stall); else pass++;
        total++; if (ram_write_enable !== 1'b0) $display("FAIL rst_ramwe got %b exp 0", ram_write_enable); else pass++;
        tick();
        drv(0, STA, 0, 0); #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL rst_push_suppr got %b exp 0", tx_valid); else pass++;
        total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_status got %h exp 0", cpu_rdata); else pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] b [3];
        b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drv(1, BASE, {24'h0, b[i]}, 1); else drv(0, 16'h0, 0, 1);
            #1;
            total++; if (ram_write_enable !== 1'b0) $display("FAIL basic_ramwe[%0d] got %b exp 0", i, ram_write_enable); else pass++;
            if (i > 0) begin
                total++; if (tx_valid !== 1'b1 || tx_data !== b[i-1])
                    $display("FAIL basic_tx[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, b[i-1]); else pass++;
            end
            tick();
        end
        drv(0, SNT, 0, 0); #1;
        total++; if (cpu_rdata !== 32'd3) $display("FAIL basic_sent got %0d exp 3", cpu_rdata); else pass++;
        total++; if (tx_valid !== 1'b0) $display("FAIL basic_empty got %b exp 0", tx_valid); else pass++;
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            drv(1, BASE, i, 0); #1;
            total++; if (cpu_stall !== 1'b0) $display("FAIL full_nostall[%0d] got %b exp 0", i, cpu_stall); else pass++;
            tick();
        end
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0000_0801) $display("FAIL full_status got %h exp 00000801", cpu_rdata); else pass++;
        tick();
        drv(1, BASE, 8, 0); #1;
        total++; if (cpu_stall !== 1'b1) $display("FAIL full_stall got %b exp 1", cpu_stall); else pass++;
        tick();
        drv(1, BASE, 8, 1); #1;
        total++; if (cpu_stall !== 1'b1 || tx_data !== 8'h00)
            $display("FAIL full_stall_pop got s=%b d=%h exp s=1 d=00", cpu_stall, tx_data); else pass++;
        tick();
        drv(1, BASE, 8, 0); #1;
        total++; if (cpu_stall !== 1'b0) $display("FAIL full_unstall got %b exp 0", cpu_stall); else pass++;
        tick();
        for (int i = 1; i <= 8; i++) begin
            drv(0, 16'h0, 0, 1); #1;
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i))
                $display("FAIL full_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(i)); else pass++;
            tick();
        end
        drv(1, STA, 32'h2, 0); tick();
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0) $display("FAIL full_end_status got %h exp 0", cpu_rdata); else pass++;
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] head;
        for (int i = 0; i < D; i++) begin drv(1, BASE, $urandom, 0); tick(); end
        head = mq[0];
        drv(1, BASE, 32'hAA, 0); tick();
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0000_0803 || cpu_rdata !== mstatus())
            $display("FAIL ovf_set got %h exp 00000803", cpu_rdata); else pass++;
        tick();
        drv(1, STA, 32'h2, 0); tick();
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0000_0801) $display("FAIL ovf_clear got %h exp 00000801", cpu_rdata); else pass++;
        total++; if (tx_data !== head) $display("FAIL ovf_head got %h exp %h", tx_data, head); else pass++;
        tick();
        for (int i = 0; i < D + 2 && mq.size() > 0; i++) begin
            drv(0, 16'h0, 0, 1); #1;
            total++; if (tx_valid !== 1'b1 || tx_data !== mq[0])
                $display("FAIL ovf_drain[%0d] got v=%b d=%h exp %h", i, tx_valid, tx_data, mq[0]); else pass++;
            tick();
        end
    endtask

    task automatic test_ram();
        drv(1, 16'h0100, 32'h1234_5678, 0); #1;
        total++; if (ram_write_enable !== 1'b1 || ram_address !== 16'h0100 || ram_wdata !== 32'h1234_5678)
            $display("FAIL ram_wr got we=%b a=%h d=%h exp we=1 a=0100 d=12345678", ram_write_enable, ram_address, ram_wdata); else pass++;
        tick();
        drv(0, 16'h0100, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL ram_rd got %h exp 12345678", cpu_rdata); else pass++;
        tick();
        drv(1, 16'hFFFC, 32'h77, 0); #1;
        total++; if (ram_write_enable !== 1'b1 || cpu_stall !== 1'b0)
            $display("FAIL ram_window_gap got we=%b s=%b exp we=1 s=0", ram_write_enable, cpu_stall); else pass++;
        tick();
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0) $display("FAIL ram_count got %h exp 0", cpu_rdata); else pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin drv(1, BASE, 32'h60 + i, 0); tick(); end
        drv(0, 16'h0, 0, 1);
        rst_n = 1'b0; #1;
        mq.delete(); msent = 0; movf = 1'b0;
        total++; if (tx_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", tx_valid); else pass++;
        tick();
        rst_n = 1'b1;
        drv(0, STA, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0) $display("FAIL rstmid_status got %h exp 0", cpu_rdata); else pass++;
        tick();
        drv(0, SNT, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0) $display("FAIL rstmid_sent got %h exp 0", cpu_rdata); else pass++;
        tick();
    endtask

    task automatic test_sent_wrap();
        drv(0, 16'h0, 0, 0);
        force dut.sent_q = 32'hFFFF_FFFF; #1;
        release dut.sent_q;
        msent = 32'hFFFF_FFFF;
        drv(1, BASE, 32'h5A, 0); tick();
        drv(0, 16'h0, 0, 1); tick();
        drv(0, SNT, 0, 0); #1;
        total++; if (cpu_rdata !== 32'h0 || cpu_rdata !== msent)
            $display("FAIL sent_wrap got %h exp 00000000", cpu_rdata); else pass++;
        tick();
    endtask

    task automatic test_random();
        int sel;
        logic [15:0] ra;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 6);
            ra = 16'($urandom_range(0, 255) << 2);
            case (sel)
                0, 1, 2: drv(1, BASE, $urandom, $urandom_range(0, 1));
                3:       drv($urandom_range(0, 1), STA, $urandom, $urandom_range(0, 1));
                4:       drv(0, SNT, 0, $urandom_range(0, 1));
                5:       drv(1, ra, $urandom, $urandom_range(0, 1));
                default: drv(0, ra, 0, $urandom_range(0, 1));
            endcase
            #1;
            total++; if (cpu_stall !== mstall()) $display("FAIL rnd_stall[%0d] got %b exp %b", i, cpu_stall, mstall()); else pass++;
            total++; if (tx_valid !== (mq.size() != 0)) $display("FAIL rnd_valid[%0d] got %b exp %b", i, tx_valid, mq.size() != 0); else pass++;
            if (mq.size() != 0) begin
                total++; if (tx_data !== mq[0]) $display("FAIL rnd_data[%0d] got %h exp %h", i, tx_data, mq[0]); else pass++;
            end
            if (sel == 3) begin
                total++; if (cpu_rdata !== mstatus()) $display("FAIL rnd_status[%0d] got %h exp %h", i, cpu_rdata, mstatus()); else pass++;
            end else if (sel == 4) begin
                total++; if (cpu_rdata !== msent) $display("FAIL rnd_sent[%0d] got %h exp %h", i, cpu_rdata, msent); else pass++;
            end else if (sel == 6) begin
                total++; if (cpu_rdata !== ram_mem[ra[9:2]]) $display("FAIL rnd_ram[%0d] got %h exp %h", i, cpu_rdata, ram_mem[ra[9:2]]); else pass++;
            end
            tick();
        end
        for (int i = 0; i < D + 2 && mq.size() > 0; i++) begin
            drv(0, 16'h0, 0, 1); #1;
            total++; if (tx_data !== mq[0]) $display("FAIL rnd_drain[%0d] got %h exp %h", i, tx_data, mq[0]); else pass++;
            tick();
        end
        drv(0, SNT, 0, 0); #1;
        total++; if (cpu_rdata !== msent) $display("FAIL rnd_final_sent got %h exp %h", cpu_rdata, msent); else pass++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_ram();
        test_reset_mid();
        test_sent_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass, total);
        $fatal(1, "timeout");
    end
endmodule
